// File: rtl/dvfs_req_arbiter.sv
// dvfs_req_arbiter: merges performance-profile votes from NUM_REQ requesters
// into a single DVFS controller request. The highest vote wins, the result is
// limited by a thermal cap, and downward moves must persist before they are
// issued. Each change is tracked through the controller's busy handshake,
// with timeouts on both the acknowledge and the completion.
//
// Optional feature macro: DVFS_ARB_THERMAL_EN
//   defined   - thermal_cap limits the target, and a cap below the active
//               profile forces an immediate drop that skips the down delay.
//   undefined - the cap is fixed at 4 and thermal_cap is ignored.
module dvfs_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_CYC = 256,
  parameter int DOWN_DLY = 64,
  parameter int ACK_TO   = 16,
  parameter int DONE_TO  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_level,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [2:0]           thermal_cap,
  output logic [3:0]           dvfs_request,
  input  logic                 dvfs_busy,
  output logic [2:0]           active_profile,
  output logic                 change_pending,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  // One timer serves the ack, done and hold phases, so it is sized for the
  // longest of them.
  localparam int TMR_MAX = (DONE_TO > HOLD_CYC) ?
                           ((DONE_TO > ACK_TO) ? DONE_TO : ACK_TO) :
                           ((HOLD_CYC > ACK_TO) ? HOLD_CYC : ACK_TO);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TO - 1);
  localparam logic [TMR_W-1:0] DONE_LAST = TMR_W'(DONE_TO - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);
  localparam logic [15:0]      DN_LAST   = 16'(DOWN_DLY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WACK  = 2'd1,
    ST_WDONE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Profile codes above 4 are treated as 4.
  function automatic logic [2:0] f_clamp_lvl(input logic [2:0] lvl);
    return (lvl > 3'd4) ? 3'd4 : lvl;
  endfunction

  // The down counter sticks at its maximum value instead of wrapping.
  function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_vote [NUM_REQ];
  logic [2:0]       r_active;
  logic [2:0]       r_pending;
  logic [3:0]       r_dvfs_req;
  logic [TMR_W-1:0] r_tmr;
  logic [15:0]      r_dn_cnt;
  logic             r_to_err;

  logic [2:0]       w_cap;
  logic             w_forced;
  logic [2:0]       w_vmax;
  logic [2:0]       w_target;
  logic             w_up;
  logic             w_down;
  logic             w_eligible;
  logic             w_ready;
  logic             w_issue;
  logic             w_commit;
  logic             w_to_set;
  logic             w_tmr_clr;

`ifdef DVFS_ARB_THERMAL_EN
  assign w_cap    = f_clamp_lvl(thermal_cap);
  assign w_forced = (w_cap < r_active);
`else
  logic w_unused_cap;
  assign w_unused_cap = ^thermal_cap;
  assign w_cap        = 3'd4;
  assign w_forced     = 1'b0;
`endif

  // Votes are only taken while no change is in flight; reset forces ready low.
  assign w_ready   = ~rst & ((r_state == ST_IDLE) | (r_state == ST_HOLD));
  assign req_ready = {NUM_REQ{w_ready}};

  // Max-wins over the registered votes, then limited by the cap.
  always_comb begin
    w_vmax = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_vote[i] > w_vmax) w_vmax = r_vote[i];
    end
  end

  assign w_target   = (w_vmax > w_cap) ? w_cap : w_vmax;
  assign w_up       = (w_target > r_active);
  assign w_down     = (w_target < r_active) & ((r_dn_cnt >= DN_LAST) | w_forced);
  assign w_eligible = w_up | w_down;

  // Capture accepted votes; every requester restarts at the mid profile.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_vote[i] <= 3'd2;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) r_vote[i] <= f_clamp_lvl(req_level[3*i +: 3]);
      end
    end
  end

  // Count how long the target has stayed below the active profile.
  always_ff @(posedge clk) begin
    if (rst)                       r_dn_cnt <= 16'd0;
    else if (w_target < r_active)  r_dn_cnt <= f_sat_inc16(r_dn_cnt);
    else                           r_dn_cnt <= 16'd0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle actions for the datapath registers.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_commit    = 1'b0;
    w_to_set    = 1'b0;
    w_tmr_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_issue     = 1'b1;
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_WACK;
        end
      end
      ST_WACK: begin
        if (dvfs_busy) begin
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_WDONE;
        end else if (r_tmr == ACK_LAST) begin
          // No acknowledge: assume the controller applied the request anyway.
          w_to_set    = 1'b1;
          w_commit    = 1'b1;
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_WDONE: begin
        if (!dvfs_busy) begin
          w_commit    = 1'b1;
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (r_tmr == DONE_LAST) begin
          // Completion never seen: keep the old active profile.
          w_to_set    = 1'b1;
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_tmr == HOLD_LAST) begin
          w_tmr_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request, pending/active profile, phase timer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvfs_req <= 4'h2;
      r_pending  <= 3'd2;
      r_active   <= 3'd2;
      r_tmr      <= '0;
      r_to_err   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_dvfs_req <= {1'b0, w_target};
        r_pending  <= w_target;
      end
      if (w_commit) r_active <= r_pending;
      if (w_tmr_clr)               r_tmr <= '0;
      else if (r_state != ST_IDLE) r_tmr <= r_tmr + TMR_W'(1);
      if (w_to_set)     r_to_err <= 1'b1;
      else if (err_clr) r_to_err <= 1'b0;
    end
  end

  assign dvfs_request   = r_dvfs_req;
  assign active_profile = r_active;
  assign timeout_err    = r_to_err;
  assign change_pending = (r_state == ST_WACK) | (r_state == ST_WDONE);

endmodule

// File: tb/tb_dvfs_req_arbiter.sv
// Bench for dvfs_req_arbiter: expected issues (level and exact cycle) are
// queued when stimulus is driven and checked by a monitor when
// change_pending rises; other results are checked inline.
module tb_dvfs_req_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int HOLD_CYC = 256;
  localparam int DOWN_DLY = 64;
  localparam int ACK_TO   = 16;
  localparam int DONE_TO  = 1024;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_level;
  logic [NUM_REQ-1:0]   req_ready;
  logic [2:0]           thermal_cap;
  logic [3:0]           dvfs_request;
  logic                 dvfs_busy;
  logic [2:0]           active_profile;
  logic                 change_pending;
  logic                 timeout_err;
  logic                 err_clr;

  dvfs_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .HOLD_CYC(HOLD_CYC),
    .DOWN_DLY(DOWN_DLY),
    .ACK_TO  (ACK_TO),
    .DONE_TO (DONE_TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_level     (req_level),
    .req_ready     (req_ready),
    .thermal_cap   (thermal_cap),
    .dvfs_request  (dvfs_request),
    .dvfs_busy     (dvfs_busy),
    .active_profile(active_profile),
    .change_pending(change_pending),
    .timeout_err   (timeout_err),
    .err_clr       (err_clr)
  );

  typedef struct {
    logic [3:0] lvl;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   busy_mode = 0;   // 0: model handshake, 1: stuck low, 2: stuck high
  int   busy_len  = 300;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] lvl, input int c);
    exp_t e;
    e.lvl = lvl;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Monitor: every rising change_pending is an issue and must match the queue.
  initial begin
    logic prev_cp;
    exp_t e;
    prev_cp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && change_pending === 1'b1 && !prev_cp) begin
        if (sb_q.size() == 0) begin
          chk_val("unexpected_issue", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk_val("issue_level", dvfs_request, e.lvl);
          chk_val("issue_cycle", cyc, e.cyc);
        end
      end
      prev_cp = (change_pending === 1'b1);
    end
  end

  // Controller model: raise busy on a new request for busy_len cycles.
  initial begin
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 0;
    dvfs_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (change_pending !== 1'b1) seen = 0;
      case (busy_mode)
        1: dvfs_busy = 1'b0;
        2: dvfs_busy = 1'b1;
        default: begin
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) dvfs_busy = 1'b0;
          end else if (change_pending === 1'b1 && !seen) begin
            dvfs_busy = 1'b1;
            cnt       = busy_len;
            seen      = 1;
          end else begin
            dvfs_busy = 1'b0;
          end
        end
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time-out, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_cp(input logic lvl, input int bound, input string tag);
    int n = 0;
    while (change_pending !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (change_pending !== lvl) chk_val(tag, change_pending, lvl);
  endtask

  task automatic vote(input int idx, input logic [2:0] lvl);
    req_level[3*idx +: 3] = lvl;
    req_valid[idx]        = 1'b1;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic vote_all(input logic [2:0] lvl);
    for (int i = 0; i < NUM_REQ; i++) req_level[3*i +: 3] = lvl;
    req_valid = '1;
    @(negedge clk);
    req_valid = '0;
  endtask

  // Wait for an issued change to complete, check the result, sit out HOLD.
  task automatic finish_change(input string tag, input logic [2:0] exp_act);
    wait_cp(1'b1, 2000, {tag, "_no_issue"});
    wait_cp(1'b0, 2000, {tag, "_no_done"});
    chk_val(tag, active_profile, exp_act);
    repeat (HOLD_CYC + 4) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst         = 1'b1;
    req_valid   = '0;
    err_clr     = 1'b0;
    thermal_cap = 3'd7;
    @(negedge clk);
    @(negedge clk);
    chk_val({tag, "_ready_in_rst"}, req_ready, 0);
    chk_val({tag, "_dvfs_req"}, dvfs_request, 2);
    chk_val({tag, "_active"}, active_profile, 2);
    chk_val({tag, "_pending"}, change_pending, 0);
    chk_val({tag, "_timeout"}, timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_val({tag, "_ready_after"}, req_ready, 4'hF);
  endtask

  initial begin
    int c;
    int x;
    rst         = 1'b1;
    req_valid   = '0;
    req_level   = '0;
    thermal_cap = 3'd7;
    err_clr     = 1'b0;

    do_reset("reset");

    // Max-wins upward with a long busy phase; ready gating during WAIT_DONE.
    busy_len = 300;
    c = cyc;
    push_exp(4'd4, c + 2);
    vote(1, 3'd4);
    wait_until(c + 5);
    chk_val("wait_done_pending", change_pending, 1);
    chk_val("wait_done_ready", req_ready, 0);
    req_level[2:0] = 3'd3;
    req_valid[0]   = 1'b1;
    wait_cp(1'b0, 400, "t1_no_done");
    chk_val("t1_done_cycle", cyc, c + 303);
    chk_val("t1_active", active_profile, 4);
    chk_val("hold_ready", req_ready, 4'hF);
    x = cyc;
    @(negedge clk);
    // r0 (held over from WAIT_DONE) is taken now; the others drop to 1.
    for (int i = 1; i < NUM_REQ; i++) req_level[3*i +: 3] = 3'd1;
    req_valid = 4'b1110;
    busy_len  = 5;
    push_exp(4'd3, x + HOLD_CYC + 1);
    @(negedge clk);
    req_valid = '0;
    finish_change("spacing_active", 3'd3);

    // Back up to 4 (an out-of-range vote counts as 4).
    c = cyc;
    push_exp(4'd4, c + 2);
    vote(1, 3'd7);
    finish_change("up_again_active", 3'd4);

    // Lower target withdrawn at cycle 30 of the delay: nothing issues.
    c = cyc;
    vote_all(3'd1);
    wait_until(c + 30);
    vote(1, 3'd4);
    wait_until(c + 150);
    chk_val("restore_no_issue", change_pending, 0);
    chk_val("restore_req", dvfs_request, 4);
    chk_val("restore_active", active_profile, 4);

    // Persistent lower target issues exactly after the down delay.
    c = cyc;
    push_exp(4'd1, c + DOWN_DLY + 1);
    vote(1, 3'd1);
    wait_until(c + DOWN_DLY);
    chk_val("hyst_not_early", change_pending, 0);
    finish_change("hyst_active", 3'd1);

    // Thermal cap below the active profile.
    c = cyc;
    push_exp(4'd4, c + 2);
    vote(1, 3'd4);
    finish_change("pre_thermal_active", 3'd4);
    c = cyc;
    thermal_cap = 3'd1;
`ifdef DVFS_ARB_THERMAL_EN
    push_exp(4'd1, c + 1);
    wait_until(c + 100);
    chk_val("thermal_drop_active", active_profile, 1);
`else
    wait_until(c + 100);
    chk_val("thermal_off_active", active_profile, 4);
    chk_val("thermal_off_req", dvfs_request, 4);
`endif
    do_reset("reset2");

    // Ack timeout with busy stuck low.
    busy_mode = 1;
    c = cyc;
    push_exp(4'd3, c + 2);
    vote(1, 3'd3);
    wait_until(c + 1 + ACK_TO);
    chk_val("ack_to_before", timeout_err, 0);
    chk_val("ack_to_pending", change_pending, 1);
    wait_until(c + 2 + ACK_TO);
    chk_val("ack_to_flag", timeout_err, 1);
    chk_val("ack_to_active", active_profile, 3);
    chk_val("ack_to_hold_cp", change_pending, 0);
    chk_val("ack_to_hold_ready", req_ready, 4'hF);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_val("err_clr", timeout_err, 0);
    repeat (HOLD_CYC + 4) @(negedge clk);

    // Done timeout with busy stuck high; clear in the same cycle loses.
    busy_mode = 2;
    c = cyc;
    push_exp(4'd4, c + 2);
    vote(1, 3'd4);
    wait_until(c + 2 + DONE_TO);
    chk_val("done_to_before", timeout_err, 0);
    chk_val("done_to_pending", change_pending, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_val("done_to_set_wins", timeout_err, 1);
    chk_val("done_to_active", active_profile, 3);
    chk_val("done_to_hold_cp", change_pending, 0);
    push_exp(4'd4, c + 3 + DONE_TO + HOLD_CYC + 1);
    wait_until(c + DONE_TO + HOLD_CYC + 10);
    chk_val("retry_pending", change_pending, 1);

    // Reset in WAIT_DONE abandons the change and restores the votes.
    do_reset("mid_rst");
    busy_mode = 0;
    repeat (80) @(negedge clk);
    chk_val("post_rst_idle", change_pending, 0);
    chk_val("post_rst_req", dvfs_request, 2);
    c = cyc;
    push_exp(4'd3, c + 2);
    vote(0, 3'd3);
    finish_change("post_rst_active", 3'd3);

    chk_val("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
